tx_serializer: RTL and testbench
================================

# tx_serializer

Parametrised serial transmitter: accepts pre-encoded line symbols (e.g. 10-bit 8b10b codes) over a valid/ready stream into a small FIFO and shifts them out one bit per `clk_bit` cycle. When no data is available it fills the line with an idle/comma symbol. It can also emit a PRBS sequence, a forced idle stream or a 1010 clock pattern for link bring-up. It sits between the symbol encoder and the optical output pin, and replaces the fixed-width, fixed-LFSR transmitter.

## Interface
- `SYM_W`, 10, symbol width in bits (≥2)
- `DEPTH`, 4, symbol FIFO depth, power of two ≥2
- `IDLE_SYM`, 10'b0011111010, symbol sent when the FIFO underflows or in idle mode (K28.5, RD−)
- `MSB_FIRST`, 0, 0 = bit 0 of symbol sent first, 1 = bit SYM_W−1 first
- `LFSR_W`, 16, PRBS register width
- `PRBS_TAPS`, 16'hB400, feedback mask (x^16+x^14+x^13+x^11)
- `PRBS_SEED`, 16'h5678, LFSR reset value, nonzero
- `clk_bit  in  1  bit clock, one line bit per cycle`
- `rst  in  1  asynchronous, active-high reset`
- `s_data  in  SYM_W  symbol to transmit`
- `s_valid  in  1  s_data valid`
- `s_ready  out  1  FIFO can accept; transfer on s_valid&&s_ready at posedge`
- `mode  in  2  0 DATA, 1 PRBS, 2 IDLE, 3 CLKPAT`
- `out  out  1  serial line bit, registered`
- `sym_start  out  1  high in the cycle `out` carries the first bit of a symbol`
- `underflow  out  1  one-cycle pulse: a DATA-mode symbol slot was filled with IDLE_SYM`

## Operation
- Reset values: `out`=0, `sym_start`=0, `underflow`=0, `s_ready`=0 while `rst` is high. Internally, bit index=0, current symbol=IDLE_SYM, mode_q=DATA, LFSR=PRBS_SEED, FIFO empty.
- `s_ready` = !rst && (count < DEPTH). It is derived from registered count and has no combinational path from `s_valid`.
- Bit index counts 0..SYM_W−1 and wraps; it runs in all modes.
- Load edge: the edge where bit index == SYM_W−1. At this edge `mode` is sampled into mode_q and the next symbol is chosen from the pre-edge state:
  - DATA: if the FIFO is non-empty, pop the head. If it is empty, load IDLE_SYM and pulse `underflow`.
  - IDLE: load IDLE_SYM; the FIFO is not popped and keeps its contents.
  - CLKPAT: load the pattern with bit i = 1 for even i and 0 for odd i.
  - PRBS: no pop.
- Every edge in DATA, IDLE and CLKPAT: `out` <= symbol bit at the bit index (or index SYM_W−1−idx when MSB_FIRST).
- Every edge in PRBS: `out` <= lfsr[LFSR_W−1], and lfsr <= {lfsr[LFSR_W−2:0], ^(lfsr & PRBS_TAPS)}.
- The LFSR holds its value outside PRBS and resumes from that state; it is not reseeded.
- `sym_start` <= (bit index == 0), registered alongside `out`.
- Mode changes take effect only at symbol boundaries; a symbol is never truncated.
- Boundary conditions:
  - Write and pop on the same edge: count is unchanged.
  - Write while full: impossible, because `s_ready` is 0.
  - Write into an empty FIFO on a load edge: the written symbol is not popped at that edge. IDLE_SYM is sent, `underflow` pulses, and the new symbol is popped at the next load edge.
  - FIFO pointers wrap modulo DEPTH.
  - `rst` asserted mid-symbol aborts the symbol immediately, and all state returns to the reset values above.

## Timing
- Throughput: one symbol per SYM_W cycles.
- A symbol popped at load edge L has bit 0 on `out` after edge L+1, and its last bit after edge L+SYM_W. `sym_start` is high for the cycle after L+1.
- Worst-case write-to-first-bit latency is SYM_W+1 cycles with an empty FIFO.
- After the FIFO goes full, `s_ready` rises the cycle after the next pop.
- After reset release, the first load edge is the (SYM_W)th edge. The first SYM_W bits on `out` come from the reset symbol IDLE_SYM, and `sym_start` pulses on the first edge after release.

## Structure
- Package `tx_pkg`: mode constants MODE_DATA/PRBS/IDLE/CLKPAT, K28_5_RDN constant, default PRBS tap/seed constants.
- Sub-module `tx_sym_fifo`, a synchronous FIFO parametrised by WIDTH and DEPTH, with outputs full, empty and count. The serializer FSM, bit counter and LFSR stay in `tx_serializer`.

## Test plan
- Reset, then DATA mode with no input: `out` repeats 0101111100 (LSB-first K28.5), `sym_start` pulses every 10 cycles, and `underflow` pulses once per symbol.
- Write 10'h2AA then 10'h155 back-to-back: after the idle symbol, the line carries 0101010101 then 1010101010 contiguously with no gap, and no underflow pulses during those two slots.
- Hold `s_valid` high for 6 symbols with DEPTH=4: `s_ready` drops after 4 accepts and re-rises one cycle after each pop. All 6 symbols are sent in order.
- Switch `mode` to PRBS mid-symbol: the current symbol completes first, then `out` matches a software model of the taps B400 from seed 5678. Return to DATA at a later boundary and the FIFO contents are sent intact.
- CLKPAT and IDLE modes with 2 symbols queued: the line shows a 1010… pattern or K28.5 respectively, and the FIFO count is unchanged.
- Assert `rst` at bit 5 of a data symbol: all outputs are 0 immediately and the FIFO is empty. After release the sequence matches the first test.

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: shared definitions for the serial transmitter.
//   tx_mode_e          line mode selected on the `mode` input
//   K28_5_RDN          default idle/comma symbol (K28.5, running disparity -)
//   PRBS_TAPS_DEFAULT  default LFSR feedback mask (x^16+x^14+x^13+x^11)
//   PRBS_SEED_DEFAULT  default LFSR reset value
package tx_pkg;

  typedef enum logic [1:0] {
    MODE_DATA   = 2'd0,
    MODE_PRBS   = 2'd1,
    MODE_IDLE   = 2'd2,
    MODE_CLKPAT = 2'd3
  } tx_mode_e;

  localparam logic [9:0]  K28_5_RDN         = 10'b0011111010;
  localparam logic [15:0] PRBS_TAPS_DEFAULT = 16'hB400;
  localparam logic [15:0] PRBS_SEED_DEFAULT = 16'h5678;

endpackage

// File: rtl/tx_sym_fifo.sv
// tx_sym_fifo: synchronous FIFO holding symbols waiting to be serialised.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  push; ignored while full
//   rd_en           pop of the head; ignored while empty
//   rd_data         current head (valid while !empty)
//   full, empty     occupancy flags derived from count
//   count           number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module tx_sym_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: serial line transmitter for pre-encoded symbols.
// Symbols arrive over a valid/ready stream into tx_sym_fifo and are shifted
// out one bit per clk_bit cycle. Empty FIFO slots are filled with IDLE_SYM.
// PRBS, forced idle and 1010 clock pattern modes support link bring-up.
// Ports:
//   clk_bit    bit clock, one line bit per cycle
//   rst        asynchronous active-high reset
//   s_data     symbol to transmit
//   s_valid    s_data valid
//   s_ready    FIFO can accept a symbol
//   mode       0 DATA, 1 PRBS, 2 IDLE, 3 CLKPAT (takes effect at symbol boundary)
//   out        registered serial line bit
//   sym_start  high while `out` carries the first bit of a symbol
//   underflow  one-cycle pulse when a DATA slot was filled with IDLE_SYM
//   dbg_mode   mode currently on the line (state register)
//   dbg_count  FIFO occupancy
//
// Handshake: a symbol is transferred on every rising clk_bit edge where
// s_valid && s_ready. s_ready depends only on the registered FIFO count
// (and rst), never on s_valid; once s_valid is raised the source holds
// s_data stable until the transfer edge.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int                SYM_W     = 10,
  parameter int                DEPTH     = 4,
  parameter logic [SYM_W-1:0]  IDLE_SYM  = K28_5_RDN,
  parameter bit                MSB_FIRST = 1'b0,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] PRBS_TAPS = PRBS_TAPS_DEFAULT,
  parameter logic [LFSR_W-1:0] PRBS_SEED = PRBS_SEED_DEFAULT
) (
  input  logic                   clk_bit,
  input  logic                   rst,
  input  logic [SYM_W-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             mode,
  output logic                   out,
  output logic                   sym_start,
  output logic                   underflow,
  output logic [1:0]             dbg_mode,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int              IDX_W    = $clog2(SYM_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_W - 1);

  // Alternating pattern with bit i = 1 for even i (1010... on the line).
  function automatic logic [SYM_W-1:0] clk_pattern();
    logic [SYM_W-1:0] p;
    p = '0;
    for (int i = 0; i < SYM_W; i++) begin
      p[i] = ((i % 2) == 0);
    end
    return p;
  endfunction

  localparam logic [SYM_W-1:0] CLK_PAT = clk_pattern();

  logic [IDX_W-1:0]  bit_idx;
  logic [SYM_W-1:0]  cur_sym;
  tx_mode_e          mode_q;
  tx_mode_e          mode_in;
  logic [LFSR_W-1:0] lfsr;
  logic              load_edge;
  logic [IDX_W-1:0]  tx_idx;
  logic              sym_bit;
  logic              lfsr_fb;

  logic [SYM_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;

  assign mode_in   = tx_mode_e'(mode);
  assign load_edge = (bit_idx == LAST_IDX);
  assign tx_idx    = MSB_FIRST ? (LAST_IDX - bit_idx) : bit_idx;
  assign sym_bit   = cur_sym[tx_idx];
  assign lfsr_fb   = ^(lfsr & PRBS_TAPS);
  assign s_ready   = !rst && !fifo_full;
  // Pop only on a DATA load edge; the FIFO itself ignores pops while empty,
  // so a symbol written on that same edge waits for the next boundary.
  assign fifo_rd   = load_edge && (mode_in == MODE_DATA);
  assign dbg_mode  = mode_q;

  tx_sym_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_bit),
    .rst     (rst),
    .wr_en   (s_valid && s_ready),
    .wr_data (s_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (dbg_count)
  );

  always_ff @(posedge clk_bit or posedge rst) begin
    if (rst) begin
      bit_idx   <= '0;
      cur_sym   <= IDLE_SYM;
      mode_q    <= MODE_DATA;
      lfsr      <= PRBS_SEED;
      out       <= 1'b0;
      sym_start <= 1'b0;
      underflow <= 1'b0;
    end else begin
      bit_idx   <= load_edge ? '0 : bit_idx + IDX_W'(1);
      sym_start <= (bit_idx == '0);
      underflow <= 1'b0;

      // The line bit follows the mode of the symbol in flight (mode_q), so a
      // mode change on `mode` never truncates the current symbol.
      if (mode_q == MODE_PRBS) begin
        out  <= lfsr[LFSR_W-1];
        lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb};
      end else begin
        out  <= sym_bit;
      end

      if (load_edge) begin
        mode_q <= mode_in;
        case (mode_in)
          MODE_DATA: begin
            if (!fifo_empty) begin
              cur_sym <= fifo_head;
            end else begin
              cur_sym   <= IDLE_SYM;
              underflow <= 1'b1;
            end
          end
          MODE_IDLE:   cur_sym <= IDLE_SYM;
          MODE_CLKPAT: cur_sym <= CLK_PAT;
          MODE_PRBS:   cur_sym <= cur_sym;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: self-checking bench for tx_serializer (default parameters).
module tb_tx_serializer;

  localparam int             SYM_W = 10;
  localparam logic [SYM_W-1:0] K285 = 10'b0011111010;
  localparam logic [SYM_W-1:0] CLKP = 10'b0101010101;

  // ---------------- clock / reset ----------------
  logic             clk_bit = 1'b0;
  logic             rst     = 1'b1;
  logic [SYM_W-1:0] s_data  = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [1:0]       mode    = 2'd0;
  logic             out;
  logic             sym_start;
  logic             underflow;
  logic [1:0]       dbg_mode;
  logic [2:0]       dbg_count;

  always #5 clk_bit = ~clk_bit;

  tx_serializer dut (
    .clk_bit   (clk_bit),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mode      (mode),
    .out       (out),
    .sym_start (sym_start),
    .underflow (underflow),
    .dbg_mode  (dbg_mode),
    .dbg_count (dbg_count)
  );

  // ---------------- scoreboard ----------------
  int               total  = 0;
  int               bad    = 0;
  int               uf_cnt = 0;
  logic [SYM_W-1:0] exp_q[$];
  logic [SYM_W-1:0] got_q[$];

  // Frames line bits into symbols using sym_start; first received bit is bit 0.
  initial begin : monitor
    int               mcnt;
    logic [SYM_W-1:0] mbuf;
    mcnt = 0;
    mbuf = '0;
    forever begin
      @(negedge clk_bit);
      if (rst) begin
        mcnt = 0;
      end else begin
        if (underflow) uf_cnt++;
        if (sym_start) begin
          mbuf    = '0;
          mbuf[0] = out;
          mcnt    = 1;
        end else if (mcnt > 0) begin
          mbuf[mcnt] = out;
          mcnt++;
        end
        if (mcnt == SYM_W) begin
          got_q.push_back(mbuf);
          mcnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_bit);
    #1;
  endtask

  task automatic wait_sym_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sym_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_sym_start timeout got=0 exp=1");
    end
  endtask

  task automatic wait_got(input int n);
    int i;
    for (i = 0; i < 40 * n + 40; i++) begin
      if (got_q.size() >= n) break;
      tick();
    end
    if (got_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_got timeout got=%0d exp=%0d symbols", got_q.size(), n);
    end
  endtask

  task automatic send_sym(input logic [SYM_W-1:0] d);
    bit rdy;
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 60; i++) begin
      rdy = s_ready;
      tick();
      if (rdy) begin
        exp_q.push_back(d);
        done = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_sym timeout data=%h got=not_accepted exp=accepted", d);
    end
  endtask

  function automatic logic [SYM_W-1:0] pop_got();
    if (got_q.size() > 0) return got_q.pop_front();
    return 'x;
  endfunction

  function automatic logic [SYM_W-1:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    mode = 2'd0;
    repeat (3) tick();
    total++; if (out !== 1'b0)       begin bad++; $display("FAIL reset_out got=%b exp=0", out); end
    total++; if (sym_start !== 1'b0) begin bad++; $display("FAIL reset_sym_start got=%b exp=0", sym_start); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", dbg_count); end
    total++; if (dbg_mode !== 2'd0)  begin bad++; $display("FAIL reset_mode got=%0d exp=0", dbg_mode); end
    rst = 1'b0;
    tick();
    total++; if (sym_start !== 1'b1) begin bad++; $display("FAIL first_sym_start got=%b exp=1", sym_start); end
    total++; if (out !== K285[0])    begin bad++; $display("FAIL first_bit got=%b exp=%b", out, K285[0]); end
    total++; if (s_ready !== 1'b1)   begin bad++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_idle_fill();
    logic [SYM_W-1:0] g, e;
    int c;
    wait_sym_start();
    got_q.delete(); exp_q.delete(); uf_cnt = 0;
    repeat (3) exp_q.push_back(K285);
    wait_got(3);
    total++; if (uf_cnt !== 3) begin bad++; $display("FAIL idle_underflow_count got=%0d exp=3", uf_cnt); end
    for (int k = 0; k < 3; k++) begin
      g = pop_got(); e = pop_exp();
      total++; if (g !== e) begin bad++; $display("FAIL idle_sym[%0d] got=%h exp=%h", k, g, e); end
    end
    wait_sym_start();
    c = 0;
    do begin
      tick();
      c++;
    end while (sym_start !== 1'b1 && c < 40);
    total++; if (c !== SYM_W) begin bad++; $display("FAIL sym_start_period got=%0d exp=%0d", c, SYM_W); end
  endtask

  task automatic test_back_to_back();
    logic [SYM_W-1:0] g, e;
    wait_sym_start();
    got_q.delete(); exp_q.delete(); uf_cnt = 0;
    exp_q.push_back(K285);
    send_sym(10'h2AA);
    send_sym(10'h155);
    wait_got(2);
    total++; if (uf_cnt !== 0) begin bad++; $display("FAIL b2b_underflow got=%0d exp=0", uf_cnt); end
    wait_got(3);
    for (int k = 0; k < 3; k++) begin
      g = pop_got(); e = pop_exp();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_sym[%0d] got=%h exp=%h", k, g, e); end
    end
  endtask

  task automatic test_fill();
    logic [SYM_W-1:0] g, e;
    logic [SYM_W-1:0] d [6];
    for (int k = 0; k < 6; k++) d[k] = SYM_W'($urandom_range(0, 1023));
    wait_sym_start();
    got_q.delete(); exp_q.delete(); uf_cnt = 0;
    exp_q.push_back(K285);
    for (int k = 0; k < 4; k++) send_sym(d[k]);
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
    total++; if (dbg_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", dbg_count); end
    send_sym(d[4]);
    total++; if (sym_start !== 1'b1) begin bad++; $display("FAIL refill1_timing got=%b exp=1", sym_start); end
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL refull_s_ready got=%b exp=0", s_ready); end
    send_sym(d[5]);
    total++; if (sym_start !== 1'b1) begin bad++; $display("FAIL refill2_timing got=%b exp=1", sym_start); end
    wait_got(7);
    for (int k = 0; k < 7; k++) begin
      g = pop_got(); e = pop_exp();
      total++; if (g !== e) begin bad++; $display("FAIL fill_sym[%0d] got=%h exp=%h", k, g, e); end
    end
  endtask

  task automatic test_prbs();
    logic [SYM_W-1:0] g, e, p;
    logic [15:0] m;
    wait_sym_start();
    got_q.delete(); exp_q.delete(); uf_cnt = 0;
    exp_q.push_back(K285);
    send_sym(10'h0F3);
    send_sym(10'h30C);
    mode = 2'd1;
    wait_sym_start();
    wait_sym_start();
    total++; if (dbg_count !== 3'd2) begin bad++; $display("FAIL prbs_count got=%0d exp=2", dbg_count); end
    total++; if (dbg_mode !== 2'd1)  begin bad++; $display("FAIL prbs_mode got=%0d exp=1", dbg_mode); end
    wait_sym_start();
    mode = 2'd0;
    wait_got(6);
    g = pop_got(); e = pop_exp();
    total++; if (g !== e) begin bad++; $display("FAIL prbs_pre_sym got=%h exp=%h", g, e); end
    // x^16+x^14+x^13+x^11 Fibonacci LFSR, output taken from the top bit.
    m = 16'h5678;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < SYM_W; j++) begin
        p[j] = m[15];
        m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      end
      g = pop_got();
      total++; if (g !== p) begin bad++; $display("FAIL prbs_sym[%0d] got=%h exp=%h", k, g, p); end
    end
    for (int k = 0; k < 2; k++) begin
      g = pop_got(); e = pop_exp();
      total++; if (g !== e) begin bad++; $display("FAIL prbs_after_sym[%0d] got=%h exp=%h", k, g, e); end
    end
  endtask

  task automatic test_clkpat_idle();
    logic [SYM_W-1:0] g, e;
    wait_sym_start();
    got_q.delete(); exp_q.delete(); uf_cnt = 0;
    exp_q.push_back(K285);
    send_sym(10'h1C7);
    send_sym(10'h238);
    mode = 2'd3;
    wait_sym_start();
    wait_sym_start();
    total++; if (dbg_count !== 3'd2) begin bad++; $display("FAIL clkpat_count got=%0d exp=2", dbg_count); end
    mode = 2'd2;
    wait_sym_start();
    wait_sym_start();
    total++; if (dbg_count !== 3'd2) begin bad++; $display("FAIL idle_count got=%0d exp=2", dbg_count); end
    mode = 2'd0;
    wait_got(6);
    total++; if (uf_cnt !== 0) begin bad++; $display("FAIL forced_underflow got=%0d exp=0", uf_cnt); end
    wait_got(7);
    g = pop_got(); e = pop_exp();
    total++; if (g !== e) begin bad++; $display("FAIL cp_pre_sym got=%h exp=%h", g, e); end
    for (int k = 0; k < 2; k++) begin
      g = pop_got();
      total++; if (g !== CLKP) begin bad++; $display("FAIL clkpat_sym[%0d] got=%h exp=%h", k, g, CLKP); end
    end
    for (int k = 0; k < 2; k++) begin
      g = pop_got();
      total++; if (g !== K285) begin bad++; $display("FAIL idle_mode_sym[%0d] got=%h exp=%h", k, g, K285); end
    end
    for (int k = 0; k < 2; k++) begin
      g = pop_got(); e = pop_exp();
      total++; if (g !== e) begin bad++; $display("FAIL cp_after_sym[%0d] got=%h exp=%h", k, g, e); end
    end
  endtask

  task automatic test_rst_mid();
    logic [SYM_W-1:0] g, e;
    wait_sym_start();
    got_q.delete(); exp_q.delete();
    send_sym(10'h3E0);
    send_sym(10'h01F);
    wait_sym_start();
    repeat (5) tick();
    total++; if (out !== 1'b1) begin bad++; $display("FAIL pre_rst_bit5 got=%b exp=1", out); end
    rst = 1'b1;
    #1;
    total++; if (out !== 1'b0)       begin bad++; $display("FAIL midrst_out got=%b exp=0", out); end
    total++; if (sym_start !== 1'b0) begin bad++; $display("FAIL midrst_sym_start got=%b exp=0", sym_start); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL midrst_underflow got=%b exp=0", underflow); end
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL midrst_s_ready got=%b exp=0", s_ready); end
    total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", dbg_count); end
    repeat (2) tick();
    got_q.delete(); exp_q.delete(); uf_cnt = 0;
    repeat (3) exp_q.push_back(K285);
    rst = 1'b0;
    tick();
    total++; if (sym_start !== 1'b1) begin bad++; $display("FAIL rerelease_sym_start got=%b exp=1", sym_start); end
    wait_got(3);
    total++; if (uf_cnt !== 3) begin bad++; $display("FAIL rerelease_underflow got=%0d exp=3", uf_cnt); end
    for (int k = 0; k < 3; k++) begin
      g = pop_got(); e = pop_exp();
      total++; if (g !== e) begin bad++; $display("FAIL rerelease_sym[%0d] got=%h exp=%h", k, g, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_fill();
    test_back_to_back();
    test_fill();
    test_prbs();
    test_clkpat_idle();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
